key_schedule_seq: RTL
=====================

# key_schedule_seq

Sequential, runtime-configurable AES key schedule supporting AES-128, AES-192 and AES-256 from one instance. The block generates one 32-bit schedule word per clock, replacing an unrolled combinational expansion. It stores the full schedule in an internal word buffer and serves any round key through a registered read port. It sits between the key-load interface and the round datapath of the cipher core.

## Interface
- `MAX_NK`, default 8: largest key size in words (4, 6 or 8). Sizes the buffer to 4·(MAX_NK+7) words. Modes above MAX_NK are rejected.
- `IDX_W`, default 4: width of the round index.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle request. Latches `key_in` and `mode`.
- `mode` in 2: key size. 0 = AES-128 (nk=4, nr=10), 1 = AES-192 (nk=6, nr=12), 2 = AES-256 (nk=8, nr=14), 3 = illegal.
- `key_in` in 256: key, MSB-aligned. Word 0 = [255:224]. Unused low words are ignored.
- `busy` out 1: generation in progress.
- `done` out 1: level signal. The schedule is complete and valid.
- `err` out 1: one-cycle pulse when a start is rejected.
- `rd_idx` in IDX_W: round key index, 0..nr.
- `rd_key` out 128: round key `rd_idx`. Word 4·rd_idx is in [127:96].

## Operation
- **States**: IDLE, GEN.
  - IDLE → GEN when `start` is high, the mode is legal, and the mode's nk ≤ MAX_NK. On that edge: key words 0..nk-1 are written, i = nk, rcon = 0x01, `done` clears.
  - An illegal or oversize mode: `err` pulses, state stays IDLE, `done` and the buffer are unchanged.
  - `start` while in GEN is ignored. No `err`.
- **Per GEN cycle**, with w = word[i-1]:
  - i mod nk = 0: word[i] = word[i-nk] ^ SubWord(RotWord(w)) ^ {rcon, 24'h0}. Then rcon = xtime(rcon), where 0x80 → 0x1B.
  - nk = 8 and i mod nk = 4: word[i] = word[i-nk] ^ SubWord(w).
  - Otherwise: word[i] = word[i-nk] ^ w.
  - i mod nk is tracked with a wrap counter, not a divider.
- **Termination**: GEN → IDLE on the edge that writes word 4·(nr+1)-1. `done` sets on that same edge.
- **Read port**: `rd_key` is registered.
  - Returns 0 when `done` = 0 or `rd_idx` > nr.
- **Reset** (including mid-GEN): state IDLE, `busy` = 0, `done` = 0, `err` = 0, `rd_key` = 0, rcon = 0x01.
  - Buffer contents are not cleared. They are unreachable until the next `done`.

## Timing
- `start` sampled at edge E0. Generated words are written on edges E1..E(4(nr+1)-nk).
- `done` rises after edge E40, E46 or E52 for AES-128, -192 and -256 respectively.
- `busy` is high from after E0 until the `done` edge.
- Read latency: `rd_idx` at edge E gives `rd_key` after E. This is one cycle, and applies whenever `done` is already high.
- Maximum combinational depth per cycle: one S-box ×4 in parallel, plus 3 XORs.

## Configuration
- `KEY_SCHED_STREAM_EN` defined:
  - Adds outputs `rk_valid` (1 bit), `rk_idx` (IDX_W) and `rk_data` (128).
  - Each round key is emitted once, in order, at most one per cycle, with a one-cycle `rk_valid` pulse.
  - Round keys held entirely in the input key (rounds 0..floor(nk/4)-1) are emitted after E1, E2, ….
  - Each generated round key is emitted the cycle after its last word is written.
  - All three outputs reset to 0.
- Not defined: these ports are absent. Behaviour is otherwise identical.

## Test plan
- **AES-128**: mode 0, key 2b7e1516 28aed2a6 abf71588 09cf4f3c.
  - Required: `done` after E40.
  - Required: `rd_idx` = 10 → d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - Required: `rd_idx` = 0 → the key.
- **AES-192**: mode 1, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b.
  - Required: `done` after E46.
  - Required: `rd_idx` = 12 → e98ba06f 448c773c 8ecc7204 01002202.
- **AES-256**: mode 2, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4.
  - Required: `done` after E52.
  - Required: `rd_idx` = 14 → fe4890d1 e6188d0b 046df344 706c631e.
- **Rejects and ignores**:
  - mode 3 → `err` pulse, `busy` stays 0, prior `done` and schedule retained.
  - `start` while busy → ignored, result matches the first request.
  - `rd_idx` = 15 → 0.
- **Reset mid-GEN**: assert `rst_n` = 0 at E20 of AES-256.
  - Required: `busy` = `done` = `rd_key` = 0 immediately.
  - Required: a subsequent AES-128 start gives the correct round 10 key after E40.
- **Stream build**: AES-256 vector.
  - Required: exactly 15 `rk_valid` pulses, indices 0..14 in order.
  - Required: the last pulse coincides with `done` rising, and its `rk_data` = fe4890d1….

Source files
------------

// File: rtl/key_schedule_seq.sv
// rtl/key_schedule_seq.sv - sequential AES-128/192/256 key schedule, one word per clock, buffered round-key read port.
// Optional round-key stream outputs are enabled with `define KEY_SCHED_STREAM_EN.
module key_schedule_seq #(
  parameter int MAX_NK = 8,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [255:0]     key_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [127:0]     rd_key
`ifdef KEY_SCHED_STREAM_EN
  ,
  output logic             rk_valid,
  output logic [IDX_W-1:0] rk_idx,
  output logic [127:0]     rk_data
`endif
);

  localparam int BUF_WORDS = 4 * (MAX_NK + 7);
  localparam int AW        = $clog2(BUF_WORDS);

  typedef enum logic {S_IDLE = 1'b0, S_GEN = 1'b1} state_e;

  state_e         state_q;
  logic [AW-1:0]  i_q;
  logic [2:0]     mod_q;
  logic [3:0]     nk_q;
  logic [3:0]     nr_q;
  logic [AW-1:0]  last_q;
  logic [7:0]     rcon_q;
  logic           busy_q;
  logic           done_q;
  logic           err_q;
  logic [127:0]   rd_key_q;
  logic [31:0]    kbuf_q [BUF_WORDS];

  logic [3:0]     dec_nk;
  logic [3:0]     dec_nr;
  logic           mode_ok;
  logic           start_acc;
  logic [31:0]    w_prev;
  logic [31:0]    w_back;
  logic [31:0]    sub_in;
  logic [31:0]    sub_out;
  logic [31:0]    new_word;
  logic [AW-1:0]  rd_base;
  logic [127:0]   rd_key_d;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as inverse (a^254, zero maps to zero) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    dec_nk = 4'd0;
    case (mode)
      2'd0:    dec_nk = 4'd4;
      2'd1:    dec_nk = 4'd6;
      2'd2:    dec_nk = 4'd8;
      default: dec_nk = 4'd0;
    endcase
  end

  assign dec_nr    = dec_nk + 4'd6;
  assign mode_ok   = (mode != 2'd3) && (32'(dec_nk) <= MAX_NK);
  assign start_acc = (state_q == S_IDLE) && start && mode_ok;

  assign w_prev = kbuf_q[i_q - AW'(1)];
  assign w_back = kbuf_q[i_q - AW'(nk_q)];

  // One shared SubWord: rotated input on nk boundaries, plain input on the AES-256 half-way word
  assign sub_in  = (mod_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};

  always_comb begin
    new_word = w_back ^ w_prev;
    if (mod_q == 3'd0) begin
      new_word = w_back ^ sub_out ^ {rcon_q, 24'h0};
    end else if ((nk_q == 4'd8) && (mod_q == 3'd4)) begin
      new_word = w_back ^ sub_out;
    end
  end

  assign rd_base = AW'({rd_idx, 2'b00});

  always_comb begin
    rd_key_d = 128'h0;
    if (done_q && (32'(rd_idx) <= 32'(nr_q))) begin
      rd_key_d = {kbuf_q[rd_base], kbuf_q[rd_base + AW'(1)],
                  kbuf_q[rd_base + AW'(2)], kbuf_q[rd_base + AW'(3)]};
    end
  end

  // Word buffer is deliberately not reset; done gates every read of it
  always_ff @(posedge clk) begin
    if (start_acc) begin
      for (int k = 0; k < MAX_NK; k++) begin
        if (k < int'(dec_nk)) kbuf_q[AW'(k)] <= key_in[8'(255 - 32 * k) -: 32];
      end
    end else if (state_q == S_GEN) begin
      kbuf_q[i_q] <= new_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      mod_q    <= 3'd0;
      nk_q     <= 4'd0;
      nr_q     <= 4'd0;
      last_q   <= '0;
      rcon_q   <= 8'h01;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_key_q <= 128'h0;
    end else begin
      err_q    <= 1'b0;
      rd_key_q <= rd_key_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (mode_ok) begin
              state_q <= S_GEN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              i_q     <= AW'(dec_nk);
              mod_q   <= 3'd0;
              rcon_q  <= 8'h01;
              nk_q    <= dec_nk;
              nr_q    <= dec_nr;
              last_q  <= AW'({dec_nr, 2'b11});
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_GEN: begin
          i_q   <= i_q + AW'(1);
          mod_q <= ({1'b0, mod_q} == (nk_q - 4'd1)) ? 3'd0 : mod_q + 3'd1;
          if (mod_q == 3'd0) rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          if (i_q == last_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign rd_key = rd_key_q;

`ifdef KEY_SCHED_STREAM_EN
  logic             rk_valid_q;
  logic [IDX_W-1:0] rk_idx_q;
  logic [127:0]     rk_data_q;
  logic [1:0]       kpend_q;
  logic [IDX_W-1:0] kidx_q;
  logic [AW-1:0]    k_base;

  assign k_base = AW'({kidx_q, 2'b00});

  // Generated round keys take priority; the key-only rounds drain in the first GEN cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_valid_q <= 1'b0;
      rk_idx_q   <= '0;
      rk_data_q  <= 128'h0;
      kpend_q    <= 2'd0;
      kidx_q     <= '0;
    end else begin
      rk_valid_q <= 1'b0;
      if (start_acc) begin
        kpend_q <= dec_nk[3:2];
        kidx_q  <= '0;
      end else if (state_q == S_GEN) begin
        if (i_q[1:0] == 2'b11) begin
          rk_valid_q <= 1'b1;
          rk_idx_q   <= IDX_W'(i_q >> 2);
          rk_data_q  <= {kbuf_q[i_q - AW'(3)], kbuf_q[i_q - AW'(2)], w_prev, new_word};
        end else if (kpend_q != 2'd0) begin
          rk_valid_q <= 1'b1;
          rk_idx_q   <= kidx_q;
          rk_data_q  <= {kbuf_q[k_base], kbuf_q[k_base + AW'(1)],
                         kbuf_q[k_base + AW'(2)], kbuf_q[k_base + AW'(3)]};
          kpend_q    <= kpend_q - 2'd1;
          kidx_q     <= kidx_q + IDX_W'(1);
        end
      end
    end
  end

  assign rk_valid = rk_valid_q;
  assign rk_idx   = rk_idx_q;
  assign rk_data  = rk_data_q;
`endif

endmodule
